dest_pipeline_tracker: RTL

//  Producer side of the register-forwarding interface.
//  - Carries each instruction's destination register and write/load flags through EX, MEM and WB.
//  - Drives memRd/memRegWrite/wbRd/wbRegWrite to the forwarding unit.
//  - Detects load-use hazards that forwarding cannot cover. On a hazard it stalls IF/ID and inserts

---
 rtl/dest_pipeline_tracker.sv | 101 ++++++++++
 1 files changed

// File: rtl/dest_pipeline_tracker.sv
// Carries destination register and write/load flags through EX, MEM and WB for the forwarding
// unit, and stalls IF/ID with EX bubbles on load-use hazards that forwarding cannot cover.
module dest_pipeline_tracker #(
   parameter int unsigned REG_W             = 4,
   parameter int unsigned LOAD_STALL_CYCLES = 1,
   parameter int unsigned CNT_W             = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             idValid,
   input  logic [REG_W-1:0] idOp1,
   input  logic [REG_W-1:0] idOp2,
   input  logic [REG_W-1:0] idRd,
   input  logic             idRegWrite,
   input  logic             idMemRead,
   input  logic             flush,
   output logic [REG_W-1:0] exRd,
   output logic             exRegWrite,
   output logic             exMemRead,
   output logic [REG_W-1:0] memRd,
   output logic             memRegWrite,
   output logic [REG_W-1:0] wbRd,
   output logic             wbRegWrite,
   output logic             stall,
   output logic [CNT_W-1:0] stallCount
);

   typedef enum logic {StIdle, StStall} state_e;

   localparam logic [1:0]       RemInit = 2'(LOAD_STALL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntMax  = '1;

   state_e     state_q;
   logic [1:0] rem_q;
   logic       hazard;

   // The first stall cycle comes from the hazard itself; STALL only covers the extra bubbles.
   always_comb begin
      hazard = idValid & exMemRead & exRegWrite & ((exRd == idOp1) | (exRd == idOp2));
      stall  = 1'b0;
      if (!rst) begin
         if (state_q == StStall) begin
            stall = ~flush;
         end else begin
            stall = hazard & ~flush;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rem_q       <= 2'd0;
         exRd        <= '0;
         exRegWrite  <= 1'b0;
         exMemRead   <= 1'b0;
         memRd       <= '0;
         memRegWrite <= 1'b0;
         wbRd        <= '0;
         wbRegWrite  <= 1'b0;
         stallCount  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (stall && (LOAD_STALL_CYCLES > 1)) begin
                  state_q <= StStall;
                  rem_q   <= RemInit;
               end
            end
            StStall: begin
               rem_q <= rem_q - 2'd1;
               if ((rem_q == 2'd1) || flush) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

         // MEM and WB never stall so older instructions always drain.
         wbRd        <= memRd;
         wbRegWrite  <= memRegWrite;
         memRd       <= exRd;
         memRegWrite <= exRegWrite;

         if (stall || flush || !idValid) begin
            exRd       <= '0;
            exRegWrite <= 1'b0;
            exMemRead  <= 1'b0;
         end else begin
            exRd       <= idRd;
            exRegWrite <= idRegWrite;
            exMemRead  <= idMemRead;
         end

         if (stall && (stallCount != CntMax)) begin
            stallCount <= stallCount + CNT_W'(1);
         end
      end
   end

endmodule
